riscv_control_fsm: RTL and testbench

//   Multicycle control unit for the 64-bit RISC-V core. Consumes opcode, funct3 and alu_flags from the

---
 rtl/riscv_control_fsm.sv | 95 +++++++++
 tb/tb_riscv_control_fsm.sv | 133 +++++++++++++
 2 files changed

// File: rtl/riscv_control_fsm.sv
// riscv_control_fsm: multicycle control unit sequencing fetch/decode/execute/memory/writeback,
// counting retired instructions and halting on an illegal opcode.
module riscv_control_fsm #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [3:0]          alu_flags,
    output logic                ir_we,
    output logic                pc_we,
    output logic                pc_src,
    output logic [3:0]          alu_cmd,
    output logic                alu_src,
    output logic                rf_src,
    output logic                rf_we,
    output logic                d_mem_we,
    output logic                halted,
    output logic [CNT_BITS-1:0] instr_count
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_LD, C_ST, C_BR, C_LUI, C_JAL} cls_t;
    state_t state, state_nx;
    cls_t cls, cls_dec;
    logic boot, legal, taken, en, ex, mem_last, unused_zero;
    logic [3:0] wait_cnt;
    assign unused_zero = alu_flags[0];
    assign mem_last = wait_cnt == 4'd0;
    always_comb begin
        cls_dec = C_R;
        legal = 1'b1;
        case (opcode)
            7'b0110011: cls_dec = C_R;
            7'b0010011: cls_dec = C_I;
            7'b0000011: cls_dec = C_LD;
            7'b0100011: cls_dec = C_ST;
            7'b1100011: cls_dec = C_BR;
            7'b0110111: cls_dec = C_LUI;
            7'b1101111: cls_dec = C_JAL;
            default:    legal = 1'b0;
        endcase
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = alu_flags[3];
            3'b001:  taken = !alu_flags[3];
            3'b100:  taken = alu_flags[1] ^ alu_flags[2];
            3'b101:  taken = !(alu_flags[1] ^ alu_flags[2]);
            default: taken = 1'b0;
        endcase
    end
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   state_nx = boot ? FETCH : DECODE;
            DECODE:  state_nx = legal ? EXEC : HALT;
            EXEC:    state_nx = cls == C_BR ? FETCH : (cls == C_LD || cls == C_ST) ? MEM : WB;
            MEM:     state_nx = !mem_last ? MEM : cls == C_LD ? WB : FETCH;
            WB:      state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end
    // Reset and the boot cycle after it force every strobe low, so an abort never leaks a pulse.
    always_comb begin
        en       = !rst && !boot;
        ex       = state == EXEC || state == MEM || state == WB;
        ir_we    = en && state == FETCH;
        alu_cmd  = !(en && ex) ? 4'd0 : cls == C_R ? 4'd0 : (cls == C_I || cls == C_LD) ? 4'd1 :
                   cls == C_ST ? 4'd2 : cls == C_BR ? 4'd3 : cls == C_LUI ? 4'd4 : 4'd5;
        alu_src  = en && ex && !(cls == C_R || cls == C_BR);
        pc_we    = en && ((state == EXEC && cls == C_BR) || (state == MEM && cls == C_ST && mem_last) || state == WB);
        pc_src   = en && ((state == EXEC && cls == C_BR && taken) || (state == WB && cls == C_JAL));
        rf_src   = en && (state == MEM || state == WB) && cls == C_LD;
        rf_we    = en && state == WB;
        d_mem_we = en && state == MEM && cls == C_ST && wait_cnt == 4'(MEM_WAIT);
        halted   = !rst && state == HALT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            boot        <= 1'b1;
            cls         <= C_R;
            wait_cnt    <= 4'd0;
            instr_count <= '0;
        end else begin
            boot     <= 1'b0;
            state    <= state_nx;
            cls      <= state == DECODE ? cls_dec : cls;
            wait_cnt <= state == EXEC ? 4'(MEM_WAIT) : (state == MEM && !mem_last) ? wait_cnt - 4'd1 : wait_cnt;
            if (pc_we) instr_count <= instr_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_control_fsm.sv
// tb_riscv_control_fsm: scoreboard bench; per-cycle expected strobes are queued at issue and popped each cycle.
module tb_riscv_control_fsm;
    localparam int MW = 2;
    localparam int CB = 32;
    logic clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [3:0] alu_flags = '0;
    logic ir_we, pc_we, pc_src, alu_src, rf_src, rf_we, d_mem_we, halted;
    logic [3:0] alu_cmd;
    logic [CB-1:0] instr_count;
    logic [CB+11:0] sb[$];
    logic [CB-1:0] cnt_model = '0;
    int checks = 0, errors = 0;

    riscv_control_fsm #(.MEM_WAIT(MW), .CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .alu_flags(alu_flags),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_cmd(alu_cmd), .alu_src(alu_src),
        .rf_src(rf_src), .rf_we(rf_we), .d_mem_we(d_mem_we), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {ir_we, pc_we, pc_src, alu_cmd, alu_src, rf_src, rf_we, d_mem_we, halted};
    endfunction

    function automatic logic [11:0] ov(logic ir, logic pw, logic ps, logic [3:0] cmd,
                                       logic as, logic rs, logic rw, logic dw, logic h);
        return {ir, pw, ps, cmd, as, rs, rw, dw, h};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [11:0] o);
        sb.push_back({cnt_model, o});
    endtask

    task automatic drain(input string tag);
        logic [CB+11:0] e;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            check({tag, " outs"}, 64'(outs()), 64'(e[11:0]));
            check({tag, " count"}, 64'(instr_count), 64'(e[CB+11:12]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1 check("rst outs", 64'(outs()), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst hold outs", 64'(outs()), 64'd0);
        check("rst count", 64'(instr_count), 64'd0);
        rst = 1'b0;
        cnt_model = '0;
        #1 check("boot outs", 64'(outs()), 64'd0);
    endtask

    // keep>0 truncates the expected trace to that many cycles (used for aborted instructions)
    task automatic issue(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [3:0] fl, input logic tk, input int keep);
        logic [3:0] cmd;
        logic as;
        opcode = op;
        funct3 = f3;
        alu_flags = fl;
        push(ov(1, 0, 0, 0, 0, 0, 0, 0, 0));
        push(ov(0, 0, 0, 0, 0, 0, 0, 0, 0));
        cmd = op == 7'b0110011 ? 4'd0 : (op == 7'b0010011 || op == 7'b0000011) ? 4'd1 :
              op == 7'b0100011 ? 4'd2 : op == 7'b1100011 ? 4'd3 : op == 7'b0110111 ? 4'd4 : 4'd5;
        as = !(op == 7'b0110011 || op == 7'b1100011);
        case (op)
            7'b1100011: push(ov(0, 1, tk, cmd, as, 0, 0, 0, 0));
            7'b0100011: begin
                push(ov(0, 0, 0, cmd, as, 0, 0, 0, 0));
                for (int i = 0; i <= MW; i++) push(ov(0, i == MW, 0, cmd, as, 0, 0, i == 0, 0));
            end
            7'b0000011: begin
                push(ov(0, 0, 0, cmd, as, 0, 0, 0, 0));
                for (int i = 0; i <= MW; i++) push(ov(0, 0, 0, cmd, as, 1, 0, 0, 0));
                push(ov(0, 1, 0, cmd, as, 1, 1, 0, 0));
            end
            7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111: begin
                push(ov(0, 0, 0, cmd, as, 0, 0, 0, 0));
                push(ov(0, 1, op == 7'b1101111, cmd, as, 0, 1, 0, 0));
            end
            default: for (int i = 0; i < 20; i++) push(ov(0, 0, 0, 0, 0, 0, 0, 0, 1));
        endcase
        if (keep > 0) while (sb.size() > keep) void'(sb.pop_back());
        drain(tag);
        if (keep == 0 && op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                    7'b1100011, 7'b0110111, 7'b1101111})
            cnt_model++;
    endtask

    initial begin
        do_reset();
        issue("add",   7'b0110011, 3'b000, 4'b0000, 0, 0);
        issue("addi",  7'b0010011, 3'b000, 4'b0000, 0, 0);
        issue("lui",   7'b0110111, 3'b000, 4'b0000, 0, 0);
        issue("jal",   7'b1101111, 3'b000, 4'b0000, 0, 0);
        issue("ld",    7'b0000011, 3'b011, 4'b0000, 0, 0);
        issue("sd",    7'b0100011, 3'b011, 4'b0000, 0, 0);
        issue("beq t", 7'b1100011, 3'b000, 4'b1000, 1, 0);
        issue("beq n", 7'b1100011, 3'b000, 4'b0000, 0, 0);
        issue("bne t", 7'b1100011, 3'b001, 4'b0000, 1, 0);
        issue("bne n", 7'b1100011, 3'b001, 4'b1000, 0, 0);
        issue("blt n", 7'b1100011, 3'b100, 4'b0110, 0, 0);
        issue("blt t", 7'b1100011, 3'b100, 4'b0010, 1, 0);
        issue("bge t", 7'b1100011, 3'b101, 4'b0110, 1, 0);
        issue("bge n", 7'b1100011, 3'b101, 4'b0100, 0, 0);
        issue("f3 010", 7'b1100011, 3'b010, 4'b1111, 0, 0);
        issue("add2",  7'b0110011, 3'b000, 4'b0000, 0, 0);
        issue("illegal", 7'b1111111, 3'b000, 4'b0000, 0, 0);
        do_reset();
        issue("post-halt add", 7'b0110011, 3'b000, 4'b0000, 0, 0);
        issue("ld abort", 7'b0000011, 3'b011, 4'b0000, 0, 4);
        do_reset();
        issue("post-abort add", 7'b0110011, 3'b000, 4'b0000, 0, 0);
        issue("post-abort sd", 7'b0100011, 3'b011, 4'b0000, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
